// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned DIGIT_SEL_W   = 2;
    localparam int unsigned VALUE_W       = 14;
    localparam int unsigned MAX_VALUE     = 9999;

    // Leading-zero blanking thresholds for digits 1, 2 and 3
    localparam int unsigned LZB_TENS      = 10;
    localparam int unsigned LZB_HUNDREDS  = 100;
    localparam int unsigned LZB_THOUSANDS = 1000;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        ON    = 2'd1,
        OFF   = 2'd2
    } slot_state_e;

    // Saturate a raw value to the largest 4-digit decimal number
    function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
        return (32'(v) > MAX_VALUE) ? VALUE_W'(MAX_VALUE) : v;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit-slot timer: slot counter, wrap/restart strobes and BLANK/ON/OFF phase.
// The ON length is derived from brightness sampled on entry to each slot.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [2:0] brightness_i,
    output logic       wrap_c_o,
    output logic       restart_c_o,
    output logic       on_next_c_o
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned LEN_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    slot_state_e      state_q, state_d;
    logic             en_q;
    logic             wrap_c, restart_c;

    // Lit cycles per slot for a brightness level, never less than one
    function automatic logic [LEN_W-1:0] on_len(input logic [2:0] b);
        int unsigned len;
        len = ((REFRESH_DIV - BLANK_CYCLES) * (32'(b) + 32'd1)) >> 3;
        if (len == 0) len = 1;
        return LEN_W'(len);
    endfunction

    // Next counter, sampled ON length and phase for the coming cycle
    always_comb begin
        wrap_c    = enable_i && en_q && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        restart_c = enable_i && !en_q;
        cnt_d     = '0;
        state_d   = BLANK;
        if (enable_i && en_q && !wrap_c) cnt_d = cnt_q + CNT_W'(1);
        len_d = (cnt_d == '0) ? on_len(brightness_i) : len_q;
        if (!enable_i || (32'(cnt_d) < BLANK_CYCLES)) begin
            state_d = BLANK;
        end else if ((state_q == OFF) && (cnt_d != '0)) begin
            state_d = OFF;
        end else if ((32'(cnt_d) - BLANK_CYCLES) < 32'(len_d)) begin
            state_d = ON;
        end else begin
            state_d = OFF;
        end
    end

    // Slot counter, ON length and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            len_q   <= LEN_W'(REFRESH_DIV - BLANK_CYCLES);
            state_q <= BLANK;
            en_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            state_q <= state_d;
            en_q    <= enable_i;
        end
    end

    assign wrap_c_o    = wrap_c;
    assign restart_c_o = restart_c;
    assign on_next_c_o = (state_d == ON);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Values are committed tear-free at frame boundaries via a load/ack handshake.
// Define SEG7_LZB_EN to blank leading zeros on digits 1..3.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [2:0]             brightness,
    input  logic [VALUE_W-1:0]     value_in,
    input  logic                   value_load,
    output logic                   value_ack,
    output logic [VALUE_W-1:0]     disp_value,
    output logic [DIGIT_SEL_W-1:0] digit_select,
    output logic [NUM_DIGITS-1:0]  an,
    output logic                   frame_start
);

    logic wrap_c, restart_c, on_next_c, frame_edge_c, digit_lit_c;

    logic [DIGIT_SEL_W-1:0] digit_q, digit_d;
    logic [VALUE_W-1:0]     disp_q, disp_d;
    logic [VALUE_W-1:0]     pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   ack_q, ack_d;
    logic                   frame_q, frame_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;

    seg7_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .brightness_i (brightness),
        .wrap_c_o     (wrap_c),
        .restart_c_o  (restart_c),
        .on_next_c_o  (on_next_c)
    );

    // Digit sequencing, commit handshake and anode decode for the next cycle
    always_comb begin
        frame_edge_c = restart_c || (wrap_c && (digit_q == DIGIT_SEL_W'(NUM_DIGITS - 1)));
        digit_d      = digit_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        ack_d        = 1'b0;
        frame_d      = frame_edge_c;
        an_d         = '1;

        if (!enable || restart_c) begin
            digit_d = '0;
        end else if (wrap_c) begin
            digit_d = digit_q + DIGIT_SEL_W'(1);
        end

        // A load landing on a commit opportunity bypasses the pending slot
        if (value_load && (frame_edge_c || !enable)) begin
            disp_d     = clamp_value(value_in);
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
        end else if (frame_edge_c && pend_vld_q) begin
            disp_d     = pend_q;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
        end else if (value_load) begin
            pend_d     = clamp_value(value_in);
            pend_vld_d = 1'b1;
        end

        digit_lit_c = 1'b1;
`ifdef SEG7_LZB_EN
        case (digit_d)
            DIGIT_SEL_W'(3): digit_lit_c = (32'(disp_d) >= LZB_THOUSANDS);
            DIGIT_SEL_W'(2): digit_lit_c = (32'(disp_d) >= LZB_HUNDREDS);
            DIGIT_SEL_W'(1): digit_lit_c = (32'(disp_d) >= LZB_TENS);
            default:         digit_lit_c = 1'b1;
        endcase
`endif

        if (on_next_c && digit_lit_c) an_d = ~(NUM_DIGITS'(1) << digit_d);
    end

    // Output and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q    <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= '1;
        end else begin
            digit_q    <= digit_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
            an_q       <= an_d;
        end
    end

    assign value_ack    = ack_q;
    assign disp_value   = disp_q;
    assign digit_select = digit_q;
    assign an           = an_q;
    assign frame_start  = frame_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scheduler for the 4-digit common-anode 7-segment display in the reaction-time game. It holds a tear-free copy of the value being displayed and drives the digit decoder's `value`/`digit_select` inputs. It also generates active-low anode enables, with per-slot dead time and PWM brightness. New values from the game FSM are accepted through a load/ack handshake and committed only at frame boundaries.

Parameters:
REFRESH_DIV, 16, clock cycles per digit slot; must be >= BLANK_CYCLES+8
BLANK_CYCLES, 2, anode-off dead time at the start of each slot (ghosting suppression)
CNT_W, $clog2(REFRESH_DIV), slot counter width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; 0 = display dark
brightness  in  3  PWM level 0 (dimmest) .. 7 (full)
value_in  in  14  new value from game FSM
value_load  in  1  one-cycle request to display value_in
value_ack  out  1  one-cycle pulse when a value is committed to disp_value
disp_value  out  14  committed value, to decoder `value`
digit_select  out  2  current digit, to decoder `digit_select`
an  out  4  anode enables, active-low, one-hot-low when lit
frame_start  out  1  one-cycle pulse at start of digit-0 slot

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: disp_value=0, digit_select=0, an=4'b1111, value_ack=0, frame_start=0. Slot counter is 0, state is BLANK, pending register is empty.
- Slot counter cnt runs 0..REFRESH_DIV-1, then wraps.
- digit_select advances 0->1->2->3->0 only on wrap, so it changes while anodes are dark.
- Slot state machine:
  - BLANK (cnt < BLANK_CYCLES): an=1111.
  - ON (cnt-BLANK_CYCLES < ON_LEN): an[digit_select]=0, other anodes 1.
  - OFF (remainder of slot): an=1111.
  - ON_LEN = ((REFRESH_DIV-BLANK_CYCLES)*(brightness+1))>>3, minimum 1.
  - brightness is sampled at slot start and held for the whole slot.
- an is registered and lags the state by zero cycles relative to cnt; state and an update on the same edge.
- frame_start pulses on the cycle cnt wraps into the digit-0 slot.
- Load handshake:
  - value_load captures value_in into the pending register; values >9999 are clamped to 9999.
  - A later load before commit overwrites the pending value (latest wins).
  - Commit happens at the digit-3 to digit-0 wrap: disp_value <= pending; value_ack pulses on that same edge.
  - If value_load coincides with the wrap, value_in (clamped) commits directly and is not left pending.
- enable=0:
  - cnt and digit_select are held at 0, state is BLANK, an=1111.
  - value_load commits on the next edge with value_ack.
  - enable rising restarts at slot 0, cnt 0, with frame_start in the first cycle.
- Reset mid-frame: everything returns to reset values immediately; the pending value is discarded.

Optional Feature:
SEG7_LZB_EN
- Defined: leading-zero blanking.
  - Digit 3 is dark when disp_value<1000.
  - Digit 2 is dark when disp_value<100.
  - Digit 1 is dark when disp_value<10.
  - Digit 0 is never blanked.
  - "Dark" means an stays 1111 through ON.
- Undefined: all four digits are lit normally, so leading zeros are shown.

Decomposition:
- Package seg7_pkg:
  - State enum {BLANK, ON, OFF}.
  - NUM_DIGITS=4, DIGIT_SEL_W=2, VALUE_W=14, MAX_VALUE=9999.
  - LZB thresholds 10/100/1000.
- Sub-module seg7_slot_timer: cnt, wrap and phase (BLANK/ON/OFF) generation from REFRESH_DIV, BLANK_CYCLES and brightness.
- Top level keeps the digit sequencing, anode decode, handshake and LZB.

Test Plan:
- Reset, enable=1, brightness=7, defaults -> an=1111 for cnt 0-1, an=1110 for cnt 2-15; digit_select=1 at cycle 16; frame_start every 64 cycles.
- brightness=0 -> exactly 1 lit cycle per slot (ON_LEN=(14*1)>>3=1); brightness=3 -> 7 lit cycles.
- value_load with 1234 mid digit-1 slot -> disp_value stays old until the 3->0 wrap; value_ack is a single pulse on that cycle; disp_value=1234.
- Loads of 5 then 42 within one frame -> only 42 is committed, one ack. value_in=16000 -> disp_value=9999. Load coincident with the wrap -> commits that same edge.
- enable=0 mid-slot -> an=1111 next cycle, digit_select=0; load of 7 acks next edge. Re-enable -> frame_start, slot 0.
- With SEG7_LZB_EN, disp_value=42 -> an never drives digits 2/3 low; digits 0/1 are lit. Without the macro, all four are lit.
